// File: rtl/grid_line_sequencer.sv
// Grid outline sequencer: walks CELLS+1 vertical then CELLS+1 horizontal lines,
// feeding shared coordinates to the line drawers and gating their enables.

module grid_line_sequencer_checker (
    input logic clk,
    input logic resetn,
    input logic vEnable,
    input logic hEnable,
    input logic drawClearN,
    input logic plot,
    input logic done,
    input logic busy
);

    enables_exclusive_a: assert property (@(posedge clk) disable iff (!resetn)
        !(vEnable && hEnable));

    enable_needs_run_a: assert property (@(posedge clk) disable iff (!resetn)
        (vEnable || hEnable) |-> drawClearN);

    plot_tracks_enable_a: assert property (@(posedge clk) disable iff (!resetn)
        plot == (vEnable || hEnable));

    done_is_busy_a: assert property (@(posedge clk) disable iff (!resetn)
        done |-> busy);

    done_single_a: assert property (@(posedge clk) disable iff (!resetn)
        done |=> !done);

endmodule

module grid_line_sequencer #(
    parameter int X0    = 1,
    parameter int Y0    = 1,
    parameter int CELL  = 7,
    parameter int CELLS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic [4:0] lineX,
    output logic [4:0] lineY,
    output logic [4:0] lineDist,
    output logic       vEnable,
    output logic       hEnable,
    output logic       drawClearN,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int DIST_INT     = CELLS * CELL + 1;
    localparam int PIX_LAST_INT = 2 * (DIST_INT + 1) - 1;

    localparam logic [4:0] X0_C     = 5'(X0);
    localparam logic [4:0] Y0_C     = 5'(Y0);
    localparam logic [4:0] CELL_C   = 5'(CELL);
    localparam logic [4:0] K_LAST_C = 5'(CELLS);
    localparam logic [4:0] DIST_C   = 5'(DIST_INT);
    localparam logic [6:0] P_LAST_C = 7'(PIX_LAST_INT);

    localparam logic DIR_V = 1'b0;
    localparam logic DIR_H = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_r, state_s;
    logic [4:0] k_r, k_s;
    logic [6:0] p_r, p_s;
    logic       dir_r, dir_s;
    logic       load_s;

    logic [4:0] offset_s;
    logic [4:0] line_x_s, line_y_s;
    logic [4:0] line_x_r, line_y_r, line_dist_r;

    logic draw_s, v_en_s, h_en_s;
    logic v_en_r, h_en_r, clear_n_r, plot_r, busy_r, done_r;

    // Next-state, line index, pixel counter and direction sequencing
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        p_s     = p_r;
        dir_s   = dir_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CLEAR;
                    k_s     = 5'd0;
                    dir_s   = DIR_V;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_DRAW;
                p_s     = 7'd0;
            end
            ST_DRAW: begin
                if (p_r == P_LAST_C) begin
                    p_s = 7'd0;
                    if (k_r < K_LAST_C) begin
                        k_s     = k_r + 5'd1;
                        state_s = ST_CLEAR;
                        load_s  = 1'b1;
                    end else if (dir_r == DIR_V) begin
                        k_s     = 5'd0;
                        dir_s   = DIR_H;
                        state_s = ST_CLEAR;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    p_s = p_r + 7'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = 5'd0;
                p_s     = 7'd0;
                dir_s   = DIR_V;
            end
        endcase
    end

    // Start coordinates of the line about to be cleared
    always_comb begin
        offset_s = k_s * CELL_C;
        if (dir_s == DIR_V) begin
            line_x_s = X0_C + offset_s;
            line_y_s = Y0_C;
        end else begin
            line_x_s = X0_C;
            line_y_s = Y0_C + offset_s;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        draw_s = (state_s == ST_DRAW);
        if (dir_s == DIR_V) begin
            v_en_s = draw_s;
            h_en_s = 1'b0;
        end else begin
            v_en_s = 1'b0;
            h_en_s = draw_s;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            k_r     <= 5'd0;
            p_r     <= 7'd0;
            dir_r   <= DIR_V;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            p_r     <= p_s;
            dir_r   <= dir_s;
        end
    end

    // Line coordinate registers, updated only when a CLEAR is entered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_x_r    <= 5'd0;
            line_y_r    <= 5'd0;
            line_dist_r <= 5'd0;
        end else if (load_s) begin
            line_x_r    <= line_x_s;
            line_y_r    <= line_y_s;
            line_dist_r <= DIST_C;
        end else begin
            line_x_r    <= line_x_r;
            line_y_r    <= line_y_r;
            line_dist_r <= line_dist_r;
        end
    end

    // Drawer control and handshake output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_en_r    <= 1'b0;
            h_en_r    <= 1'b0;
            clear_n_r <= 1'b0;
            plot_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            v_en_r    <= v_en_s;
            h_en_r    <= h_en_s;
            clear_n_r <= draw_s;
            plot_r    <= draw_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign lineX      = line_x_r;
    assign lineY      = line_y_r;
    assign lineDist   = line_dist_r;
    assign vEnable    = v_en_r;
    assign hEnable    = h_en_r;
    assign drawClearN = clear_n_r;
    assign plot       = plot_r;
    assign busy       = busy_r;
    assign done       = done_r;

    grid_line_sequencer_checker u_checker (
        .clk        (clk),
        .resetn     (resetn),
        .vEnable    (vEnable),
        .hEnable    (hEnable),
        .drawClearN (drawClearN),
        .plot       (plot),
        .done       (done),
        .busy       (busy)
    );

endmodule

// File: tb/tb_grid_line_sequencer.sv
// Bench for grid_line_sequencer: cycle-timeline reference model, drawer model
// collecting plotted pixels, spurious starts and asynchronous resets.

module tb_grid_line_sequencer;

    localparam int X0     = 1;
    localparam int Y0     = 1;
    localparam int CELL   = 7;
    localparam int CELLS  = 4;
    localparam int D      = CELLS * CELL + 1;
    localparam int LEN    = 2 * (D + 1);
    localparam int SEG    = LEN + 1;
    localparam int NL     = CELLS + 1;
    localparam int RUN    = 2 * NL * SEG;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [4:0] lineX, lineY, lineDist;
    logic       vEnable, hEnable, drawClearN, plot, busy, done;

    int checks = 0;
    int errors = 0;

    int da, dc, oob;
    int n_plot, n_v, n_h, n_ovl, n_done;
    bit pix [32][32];

    int vx_tab [10] = '{1, 8, 15, 22, 29, 1, 1, 1, 1, 1};
    int vy_tab [10] = '{1, 1, 1, 1, 1, 1, 8, 15, 22, 29};

    always #5 clk = ~clk;

    grid_line_sequencer #(.X0(X0), .Y0(Y0), .CELL(CELL), .CELLS(CELLS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .lineX      (lineX),
        .lineY      (lineY),
        .lineDist   (lineDist),
        .vEnable    (vEnable),
        .hEnable    (hEnable),
        .drawClearN (drawClearN),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_obs();
        return {11'd0, lineX, lineY, lineDist, vEnable, hEnable, drawClearN, plot, busy, done};
    endfunction

    function automatic logic [31:0] pack_exp(input int x, input int y, input int d,
                                             input bit v, input bit h, input bit cn,
                                             input bit p, input bit b, input bit dn);
        return {11'd0, 5'(x), 5'(y), 5'(d), v, h, cn, p, b, dn};
    endfunction

    function automatic bit on_grid(input int v, input int base);
        for (int k = 0; k <= CELLS; k++)
            if (v == base + k * CELL || v == base + k * CELL + 1) return 1'b1;
        return 1'b0;
    endfunction

    // Downstream drawer: along counter 0..lineDist, then toggles across bit
    task automatic sample_drawer();
        int px, py;
        if (plot) n_plot++;
        if (vEnable) n_v++;
        if (hEnable) n_h++;
        if (vEnable && hEnable) n_ovl++;
        if (done) n_done++;
        if (vEnable || hEnable) begin
            px = int'(lineX) + (vEnable ? dc : da);
            py = int'(lineY) + (vEnable ? da : dc);
            if (px < 1 || px > 30 || py < 1 || py > 30) oob++;
            else pix[px][py] = 1'b1;
            if (da == int'(lineDist)) begin
                da = 0;
                dc = dc ^ 1;
            end else begin
                da++;
            end
        end
        if (!drawClearN) begin
            da = 0;
            dc = 0;
        end
    endtask

    task automatic async_reset();
        start = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset", pack_obs(), 32'd0);
        step();
        step();
        chk("reset_hold", pack_obs(), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("post_reset_idle", pack_obs(), 32'd0);
    endtask

    // One grid run starting with a start pulse in the current idle cycle
    task automatic run(input int spur, input bit start_at_done, input int abort_at);
        int line, phase, kk, dd, ex, ey, mism;
        bit dr, want;
        pix = '{default: 1'b0};
        oob = 0; n_plot = 0; n_v = 0; n_h = 0; n_ovl = 0; n_done = 0;
        da = 0; dc = 0;
        ex = 0; ey = 0;
        start = 1'b1;
        for (int t = 1; t <= RUN + 1; t++) begin
            step();
            start = (t == spur) || (t == RUN + 1 && start_at_done);
            if (t <= RUN) begin
                line  = (t - 1) / SEG;
                phase = (t - 1) % SEG;
                kk    = line % NL;
                dd    = line / NL;
                ex    = (dd == 0) ? X0 + kk * CELL : X0;
                ey    = (dd == 0) ? Y0 : Y0 + kk * CELL;
                dr    = (phase != 0);
                chk($sformatf("cycle%0d", t), pack_obs(),
                    pack_exp(ex, ey, D, dr && dd == 0, dr && dd == 1, dr, dr, 1'b1, 1'b0));
                if (phase == 0)
                    chk($sformatf("clear_xy_line%0d", line), {22'd0, lineX, lineY},
                        {22'd0, 5'(vx_tab[line]), 5'(vy_tab[line])});
            end else begin
                chk("done_cycle", pack_obs(),
                    pack_exp(ex, ey, D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
            end
            sample_drawer();
            if (t == abort_at) begin
                async_reset();
                return;
            end
        end
        step();
        start = 1'b0;
        chk("idle_after_done", pack_obs(),
            pack_exp(X0, Y0 + CELLS * CELL, D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("plot_count", n_plot, 2 * NL * LEN);
        chk("v_count", n_v, NL * LEN);
        chk("h_count", n_h, NL * LEN);
        chk("overlap", n_ovl, 0);
        chk("done_count", n_done, 1);
        chk("out_of_range", oob, 0);
        mism = 0;
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++) begin
                want = (x >= X0 && x <= X0 + CELLS * CELL + 1 &&
                        y >= Y0 && y <= Y0 + CELLS * CELL + 1 &&
                        (on_grid(x, X0) || on_grid(y, Y0)));
                if (pix[x][y] != want) mism++;
            end
        chk("pixel_set", mism, 0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) step();
        chk("reset", pack_obs(), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat ($urandom_range(1, 5)) step();
        chk("idle", pack_obs(), 32'd0);

        run(100, 1'b1, 0);
        run($urandom_range(2, RUN), 1'b0, 0);
        run(0, 1'b0, 200);
        run(0, 1'b0, 0);
        run($urandom_range(2, RUN), 1'b0, $urandom_range(2, RUN));
        repeat ($urandom_range(1, 4)) step();
        run($urandom_range(2, RUN), 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_line_sequencer.md
Name: grid_line_sequencer

Overview:
- Upstream controller for the game-board line drawers. On a start pulse it draws the full puzzle grid outline.
- It steps through CELLS+1 vertical lines, then CELLS+1 horizontal lines.
- For each line it drives shared start coordinates and a length to the drawers, enables the correct drawer for exactly one line's worth of pixels, and clears the drawer counters between lines.
- It produces the plot strobe for the VGA writer and a done pulse for the board-drawing FSM.

Parameters:
- X0, 1, grid left edge x (pixels).
- Y0, 1, grid top edge y (pixels).
- CELL, 7, pitch between adjacent grid lines (pixels).
- CELLS, 4, cells per side; lines per direction = CELLS+1.
- Legal configuration: X0+CELLS*CELL+1 ≤ 31 and Y0+CELLS*CELL+1 ≤ 31. Other values are illegal and need not be checked.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to draw the grid.
- lineX  out  5  start x of the current line.
- lineY  out  5  start y of the current line.
- lineDist  out  5  drawer distance value, constant D = CELLS*CELL+1.
- vEnable  out  1  enable to the vertical line drawer.
- hEnable  out  1  enable to the horizontal line drawer.
- drawClearN  out  1  synchronous active-low counter clear to both drawers.
- plot  out  1  pixel-write strobe for the VGA writer.
- busy  out  1  high from acceptance of start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Drawer contract:
  - While enabled, a drawer steps its along-line counter 0..D, then wraps and advances its 1-bit across-line counter.
  - One complete 2-pixel-wide line therefore takes exactly L = 2*(D+1) enabled cycles. Default D=29, L=60.
  - The drawer's pixel output is valid combinationally in every enabled cycle.
- States: IDLE, CLEAR, DRAW, DONE.
- IDLE:
  - drawClearN=0; vEnable=hEnable=plot=busy=done=0.
  - When start=1: go to CLEAR, line index k=0, direction=vertical, busy=1 from the next cycle.
- CLEAR (1 cycle):
  - drawClearN=0; enables 0.
  - lineX/lineY are loaded for line k:
    - vertical: lineX = X0+k*CELL, lineY = Y0.
    - horizontal: lineX = X0, lineY = Y0+k*CELL.
  - lineDist = D.
  - Go to DRAW with the pixel counter p=0.
- DRAW:
  - drawClearN=1; exactly one of vEnable/hEnable = 1 (selected by direction); plot = that enable.
  - p increments each cycle. When p = L-1, this is the last enabled cycle of the line:
    - if k < CELLS: k++, go to CLEAR.
    - else if direction=vertical: k=0, direction=horizontal, go to CLEAR.
    - else go to DONE.
- DONE (1 cycle): done=1, busy=1, enables 0, drawClearN=0; then go to IDLE.
- Latency:
  - Start is sampled in cycle 0.
  - 2*(CELLS+1) lines × (1+L) cycles follow; default 610 cycles, spanning cycles 1..610.
  - done is asserted in cycle 611.
  - Total plot-high cycles = 2*(CELLS+1)*L; default 600.
- lineX/lineY/lineDist:
  - Registered; they change only on the CLEAR entry edge and are stable throughout DRAW.
  - Arithmetic is 5-bit unsigned and never exceeds 31 for legal parameters.
- The pixel counter p is 7 bits wide.
- start while busy is ignored; no queuing.
- start on the same cycle as done is ignored; a new start is accepted in the following IDLE cycle.
- Asynchronous reset, including mid-draw:
  - Immediately state=IDLE, k=0, p=0, direction=vertical.
  - lineX=lineY=lineDist=0.
  - vEnable=hEnable=plot=busy=done=0, drawClearN=0.
  - The next start after reset release restarts from line 0.
- Never assert vEnable and hEnable together.
- Never assert an enable while drawClearN=0.

Test Plan:
- Reset, then a start pulse at cycle 0 (defaults):
  - cycle 1: drawClearN=0, lineX=1, lineY=1, lineDist=29.
  - cycles 2..61: vEnable=plot=1.
  - cycle 62: clear with lineX=8.
  - done is asserted in cycle 611 only.
- Count plot during one full run: exactly 600 cycles.
  - vEnable high for 300 cycles, hEnable high for 300 cycles.
  - The two enables never overlap.
- Log lineX/lineY at each CLEAR:
  - vertical lines: (1,1),(8,1),(15,1),(22,1),(29,1).
  - horizontal lines: (1,1),(1,8),(1,15),(1,22),(1,29).
- Model the drawer behind the sequencer and collect plotted pixels:
  - the union equals the 2-pixel-wide grid, x∈{1,2,8,9,...,29,30} over y 1..30, and the transposed set.
  - No pixel outside 1..30 in either axis.
- start pulses at cycles 100 and 611 during a run:
  - both are ignored; no restart, done still in cycle 611.
  - start at cycle 612 is accepted.
- Assert resetn low asynchronously mid-line (cycle 200):
  - all outputs return to reset values without waiting for a clock edge.
  - Release and start again: the first CLEAR shows lineX=1, lineY=1, and the full 610-cycle sequence repeats.
